// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC generator: resolves next-PC from D-stage control, exception
// entry and eret, and buffers one redirect while instruction memory is not ready.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
  parameter logic [31:0] IM_BASE    = 32'h0000_3000,
  parameter int unsigned IM_WORDS   = 4096
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        imem_ready,
  input  logic        req,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        d_valid,
  input  logic [31:0] d_pc,
  input  logic [25:0] imm26,
  input  logic [15:0] imm16,
  input  logic [31:0] rs_d,
  input  logic [2:0]  npc_sel,
  input  logic        b_j,
  output logic [31:0] f_pc,
  output logic        f_valid,
  output logic        f_adel,
  output logic        f_kill,
  output logic        pend_o
);

  // Window end kept at 33 bits so a window touching 2^32 does not wrap.
  localparam logic [32:0] IM_END = {1'b0, IM_BASE} + (33'(IM_WORDS) << 2);

  logic [31:0] r_pc;
  logic        r_pend_v;
  logic [31:0] r_pend_pc;

  logic        w_take;
  logic        w_dr;
  logic [31:0] w_tgt;
  logic [31:0] w_bofs;

  assign w_bofs = {{14{imm16[15]}}, imm16, 2'b00};

  always_comb begin
    w_take = 1'b0;
    case (npc_sel)
      3'd1:    w_take = 1'b1;
      3'd2:    w_take = 1'b1;
      3'd3:    w_take = b_j;
      default: w_take = 1'b0;
    endcase
  end

  assign w_dr = d_valid & ~stall & (eret | w_take);

  always_comb begin
    w_tgt = d_pc + 32'd4 + w_bofs;
    if (eret) begin
      w_tgt = epc;
    end else begin
      case (npc_sel)
        3'd1:    w_tgt = {d_pc[31:28], imm26, 2'b00};
        3'd2:    w_tgt = rs_d;
        default: w_tgt = d_pc + 32'd4 + w_bofs;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc      <= RESET_PC;
      r_pend_v  <= 1'b0;
      r_pend_pc <= '0;
    end else if (req) begin
      r_pc     <= EXC_VECTOR;
      r_pend_v <= 1'b0;
    end else if (w_dr && eret) begin
      r_pc     <= epc;
      r_pend_v <= 1'b0;
    end else if (w_dr && imem_ready) begin
      r_pc     <= w_tgt;
      r_pend_v <= 1'b0;
    end else if (w_dr) begin
      // Delay slot not yet fetched: park the target, keep fetching at pc.
      r_pend_v  <= 1'b1;
      r_pend_pc <= w_tgt;
    end else if (r_pend_v && imem_ready && !stall) begin
      r_pc     <= r_pend_pc;
      r_pend_v <= 1'b0;
    end else if (imem_ready && !stall) begin
      r_pc <= r_pc + 32'd4;
    end
  end

  assign f_pc    = r_pc;
  assign f_valid = imem_ready;
  assign f_kill  = req | (w_dr & eret);
  assign pend_o  = r_pend_v;
  assign f_adel  = (r_pc[1:0] != 2'b00) |
                   ({1'b0, r_pc} < {1'b0, IM_BASE}) |
                   ({1'b0, r_pc} >= IM_END);

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0;
  logic        imem_ready = 1'b1;
  logic        req = 1'b0;
  logic        eret = 1'b0;
  logic [31:0] epc = '0;
  logic        d_valid = 1'b0;
  logic [31:0] d_pc = '0;
  logic [25:0] imm26 = '0;
  logic [15:0] imm16 = '0;
  logic [31:0] rs_d = '0;
  logic [2:0]  npc_sel = '0;
  logic        b_j = 1'b0;
  logic [31:0] f_pc;
  logic        f_valid, f_adel, f_kill, pend_o;

  int n_vec = 0;
  int n_err = 0;

  fetch_pc_unit #(
    .RESET_PC  (32'h0000_3000),
    .EXC_VECTOR(32'h0000_4180),
    .IM_BASE   (32'h0000_3000),
    .IM_WORDS  (4096)
  ) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .imem_ready(imem_ready),
    .req(req), .eret(eret), .epc(epc), .d_valid(d_valid), .d_pc(d_pc),
    .imm26(imm26), .imm16(imm16), .rs_d(rs_d), .npc_sel(npc_sel), .b_j(b_j),
    .f_pc(f_pc), .f_valid(f_valid), .f_adel(f_adel), .f_kill(f_kill),
    .pend_o(pend_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc = 32'h3000;
  logic        m_pv = 1'b0;
  logic [31:0] m_pp = '0;

  function automatic bit m_redirect();
    bit taken = (npc_sel == 3'd1) || (npc_sel == 3'd2) || (npc_sel == 3'd3 && b_j);
    return d_valid && !stall && (eret || taken);
  endfunction

  function automatic logic [31:0] m_target();
    int off;
    if (eret) return epc;
    if (npc_sel == 3'd1) return (d_pc & 32'hF000_0000) | (32'(imm26) * 32'd4);
    if (npc_sel == 3'd2) return rs_d;
    off = $signed(imm16);
    return d_pc + 32'd4 + 32'(off * 4);
  endfunction

  function automatic bit m_adel(input logic [31:0] pc);
    longint unsigned a = longint'(pc);
    return (a % 4 != 0) || (a < 64'h3000) || (a >= 64'h3000 + 4 * 4096);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pc <= 32'h3000;
      m_pv <= 1'b0;
      m_pp <= '0;
    end else if (req) begin
      m_pc <= 32'h4180;
      m_pv <= 1'b0;
    end else if (m_redirect() && eret) begin
      m_pc <= epc;
      m_pv <= 1'b0;
    end else if (m_redirect()) begin
      if (imem_ready) begin
        m_pc <= m_target();
        m_pv <= 1'b0;
      end else begin
        m_pv <= 1'b1;
        m_pp <= m_target();
      end
    end else if (imem_ready && !stall) begin
      m_pc <= m_pv ? m_pp : m_pc + 32'd4;
      m_pv <= 1'b0;
    end
  end

  // Single compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("f_pc",    f_pc,          m_pc);
    chk("pend_o",  32'(pend_o),   32'(m_pv));
    chk("f_valid", 32'(f_valid),  32'(imem_ready));
    chk("f_kill",  32'(f_kill),   32'(req || (m_redirect() && eret)));
    chk("f_adel",  32'(f_adel),   32'(m_adel(m_pc)));
  end

  // ---------------- directed helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    d_valid = 1'b0; eret = 1'b0; req = 1'b0; stall = 1'b0; npc_sel = 3'd0; b_j = 1'b0;
  endtask

  initial begin
    // Reset and free-run
    imem_ready = 1'b1;
    #12;
    chk("rst_pc",   f_pc, 32'h3000);
    chk("rst_pend", 32'(pend_o), 32'd0);
    chk("rst_adel", 32'(f_adel), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    chk("run0", f_pc, 32'h3000);
    step(); chk("run1", f_pc, 32'h3004);
    step(); chk("run2", f_pc, 32'h3008);

    // Taken branch back by 4 words from d_pc+4, then not-taken
    d_valid = 1'b1; d_pc = 32'h3010; npc_sel = 3'd3; b_j = 1'b1; imm16 = 16'hFFFC;
    step(); chk("br_taken", f_pc, 32'h3004);
    b_j = 1'b0;
    step(); chk("br_nt", f_pc, 32'h3008);

    // jr while imem not ready for two cycles
    npc_sel = 3'd2; rs_d = 32'h3400; imem_ready = 1'b0;
    step(); chk("jr_hold1", f_pc, 32'h3008); chk("jr_pend1", 32'(pend_o), 32'd1);
    d_valid = 1'b0;
    step(); chk("jr_hold2", f_pc, 32'h3008); chk("jr_pend2", 32'(pend_o), 32'd1);
    imem_ready = 1'b1;
    step(); chk("jr_go", f_pc, 32'h3400); chk("jr_pend0", 32'(pend_o), 32'd0);

    // eret: kill current word, target is epc itself
    d_valid = 1'b1; eret = 1'b1; epc = 32'h3020; npc_sel = 3'd0;
    #1 chk("eret_kill", 32'(f_kill), 32'd1);
    step(); chk("eret_pc", f_pc, 32'h3020);
    idle();

    // req during stall with a pending redirect
    d_valid = 1'b1; npc_sel = 3'd2; rs_d = 32'h3100; imem_ready = 1'b0;
    step(); chk("req_pend", 32'(pend_o), 32'd1);
    d_valid = 1'b0; stall = 1'b1; req = 1'b1;
    #1 chk("req_kill", 32'(f_kill), 32'd1);
    step(); chk("req_pc", f_pc, 32'h4180); chk("req_pend0", 32'(pend_o), 32'd0);
    idle(); imem_ready = 1'b1;

    // Address errors: misaligned, then first word past the window
    d_valid = 1'b1; npc_sel = 3'd2; rs_d = 32'h3002;
    step(); d_valid = 1'b0; imem_ready = 1'b0;
    #1 chk("adel_mis_pc", f_pc, 32'h3002); chk("adel_mis", 32'(f_adel), 32'd1);
    d_valid = 1'b1; rs_d = 32'h7000; imem_ready = 1'b1;
    step(); d_valid = 1'b0; imem_ready = 1'b0;
    #1 chk("adel_hi_pc", f_pc, 32'h7000); chk("adel_hi", 32'(f_adel), 32'd1);
    rs_d = 32'h6FFC; d_valid = 1'b1; imem_ready = 1'b1;
    step(); d_valid = 1'b0; imem_ready = 1'b0;
    #1 chk("adel_last", 32'(f_adel), 32'd0);

    // Async reset mid-pending
    d_valid = 1'b1; rs_d = 32'h3200;
    step(); d_valid = 1'b0;
    chk("rst_mid_pend", 32'(pend_o), 32'd1);
    reset_n = 1'b0;
    #1 chk("rst_mid_pc", f_pc, 32'h3000); chk("rst_mid_pv", 32'(pend_o), 32'd0);
    step(); reset_n = 1'b1; imem_ready = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step();
      stall      = ($urandom_range(0, 3) == 0);
      imem_ready = ($urandom_range(0, 3) != 0);
      req        = ($urandom_range(0, 19) == 0);
      eret       = ($urandom_range(0, 9) == 0);
      d_valid    = ($urandom_range(0, 3) != 0);
      npc_sel    = 3'($urandom_range(0, 7));
      b_j        = 1'($urandom);
      d_pc       = 32'h3000 + 32'($urandom_range(0, 4095)) * 4;
      if ($urandom_range(0, 15) == 0) d_pc = $urandom;
      imm26      = 26'($urandom);
      imm16      = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       rs_d = $urandom;
        1:       rs_d = 32'h3000 + 32'($urandom_range(0, 16383));
        default: rs_d = 32'h3000 + 32'($urandom_range(0, 4095)) * 4;
      endcase
      epc = ($urandom_range(0, 3) == 0) ? $urandom : 32'h3000 + 32'($urandom_range(0, 4095)) * 4;
      if ($urandom_range(0, 199) == 0) begin
        #2 reset_n = 1'b0;
        #1 reset_n = 1'b1;
      end
    end

    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
